// File: rtl/translated_read_port_buffer_pkg.sv
// translated_read_port_buffer_pkg: shared port address map and word type for the buffer bank and its downstream mux
package translated_read_port_buffer_pkg;
  localparam int WORD_WIDTH = 36;
  localparam int ADDR_WIDTH = 11;
  localparam int PORT_COUNT = 8;
  localparam int PORT_BASE_ADDR = 123;
  localparam int PORT_ADDR_WIDTH = 3;
  localparam int TOTAL_WIDTH = PORT_COUNT * WORD_WIDTH;
  typedef logic [WORD_WIDTH-1:0] word_t;
endpackage

// File: rtl/translated_read_port_buffer_decoder.sv
// translated_address_decoder: maps a read address to a port offset and flags whether it falls in the port window
//   addr     in   read address
//   offset   out  port index (addr - PORT_BASE_ADDR, low bits)
//   in_range out  addr lies in [PORT_BASE_ADDR, PORT_BASE_ADDR+PORT_COUNT)
import translated_read_port_buffer_pkg::*;
module translated_address_decoder (
  input  logic [ADDR_WIDTH-1:0]      addr,
  output logic [PORT_ADDR_WIDTH-1:0] offset,
  output logic                       in_range
);
  logic [ADDR_WIDTH-1:0] diff;
  assign diff = addr - ADDR_WIDTH'(PORT_BASE_ADDR);
  assign offset = diff[PORT_ADDR_WIDTH-1:0];
  // lower-bound compare rejects addresses below the base whose difference wraps around
  assign in_range = (addr >= ADDR_WIDTH'(PORT_BASE_ADDR)) && (diff < ADDR_WIDTH'(PORT_COUNT));
endmodule

// File: rtl/translated_read_port_buffer.sv
// translated_read_port_buffer: bank of one-word input buffers popped by translated-address reads
//   clock, reset   clock and async active-high reset
//   read_addr/en   read request shared with the downstream mux
//   port_in/valid  producer words and offers; port_in_ready back to producer
//   port_out/full  buffered words and occupancy flags
//   read_hit/miss  registered outcome of the previous-cycle read
import translated_read_port_buffer_pkg::*;
module translated_read_port_buffer (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [ADDR_WIDTH-1:0]  read_addr,
  input  logic                   read_en,
  input  logic [TOTAL_WIDTH-1:0] port_in,
  input  logic [PORT_COUNT-1:0]  port_in_valid,
  output logic [PORT_COUNT-1:0]  port_in_ready,
  output logic [TOTAL_WIDTH-1:0] port_out,
  output logic [PORT_COUNT-1:0]  port_full,
  output logic                   read_hit,
  output logic                   read_miss
);
  logic [PORT_ADDR_WIDTH-1:0] offset;
  logic in_range, sel_full, pop;
  translated_address_decoder u_dec (.addr(read_addr), .offset(offset), .in_range(in_range));
  assign sel_full = port_full[offset];
  assign pop = read_en & in_range & sel_full;
  assign port_in_ready = ~port_full & {PORT_COUNT{~reset}};
  for (genvar i = 0; i < PORT_COUNT; i++) begin : g_slot
    word_t data;
    logic full;
    // ready is ~full, so a push and a pop of the same slot never coincide
    always_ff @(posedge clock or posedge reset)
      if (reset) begin
        data <= '0;
        full <= 1'b0;
      end else if (port_in_valid[i] & ~full) begin
        data <= port_in[i*WORD_WIDTH +: WORD_WIDTH];
        full <= 1'b1;
      end else if (pop && offset == PORT_ADDR_WIDTH'(i)) begin
        full <= 1'b0;
      end
    assign port_out[i*WORD_WIDTH +: WORD_WIDTH] = data;
    assign port_full[i] = full;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      read_hit <= 1'b0;
      read_miss <= 1'b0;
    end else begin
      read_hit <= pop;
      read_miss <= read_en & in_range & ~sel_full;
    end
endmodule

// File: tb/tb_translated_read_port_buffer.sv
// tb_translated_read_port_buffer: scoreboard bench for the translated read port buffer
import translated_read_port_buffer_pkg::*;
module tb_translated_read_port_buffer;
  logic clock = 0;
  logic reset = 1;
  logic [ADDR_WIDTH-1:0] read_addr = '0;
  logic read_en = 0;
  logic [TOTAL_WIDTH-1:0] port_in = '0;
  logic [PORT_COUNT-1:0] port_in_valid = '0;
  logic [PORT_COUNT-1:0] port_in_ready;
  logic [TOTAL_WIDTH-1:0] port_out;
  logic [PORT_COUNT-1:0] port_full;
  logic read_hit, read_miss;
  translated_read_port_buffer dut (
    .clock(clock), .reset(reset), .read_addr(read_addr), .read_en(read_en),
    .port_in(port_in), .port_in_valid(port_in_valid), .port_in_ready(port_in_ready),
    .port_out(port_out), .port_full(port_full), .read_hit(read_hit), .read_miss(read_miss)
  );
  always #5 clock = ~clock;
  typedef struct {
    int kind;
    int port;
    logic [WORD_WIDTH-1:0] exp;
    string name;
  } exp_t;
  typedef struct {
    logic hit;
    logic miss;
    string name;
  } rd_t;
  exp_t sq[$];
  rd_t rq[$];
  int total = 0;
  int bad = 0;
  logic rd = 0;
  task automatic expect_state(input int kind, input int port, input logic [WORD_WIDTH-1:0] exp, input string name);
    exp_t e;
    e.kind = kind;
    e.port = port;
    e.exp = exp;
    e.name = name;
    sq.push_back(e);
  endtask
  task automatic issue_read(input int addr, input logic hit, input logic miss, input string name);
    rd_t r;
    read_addr = ADDR_WIDTH'(addr);
    read_en = 1;
    r.hit = hit;
    r.miss = miss;
    r.name = name;
    rq.push_back(r);
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  initial forever begin
    @(posedge clock);
    rd = read_en;
  end
  initial forever begin
    @(negedge clock);
    if (rd) begin
      rd_t r;
      if (rq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL read_queue_empty: read issued with no expected outcome");
      end else begin
        r = rq.pop_front();
        total++;
        if (read_hit !== r.hit || read_miss !== r.miss) begin
          bad++;
          $display("FAIL %s: got hit=%b miss=%b want hit=%b miss=%b", r.name, read_hit, read_miss, r.hit, r.miss);
        end
      end
    end else begin
      total++;
      if (read_hit !== 1'b0 || read_miss !== 1'b0) begin
        bad++;
        $display("FAIL idle_hit_miss: got hit=%b miss=%b want 0 0", read_hit, read_miss);
      end
    end
    while (sq.size() > 0) begin
      exp_t e;
      logic [WORD_WIDTH-1:0] act;
      e = sq.pop_front();
      case (e.kind)
        0: act = WORD_WIDTH'(port_full);
        1: act = WORD_WIDTH'(port_in_ready);
        2: act = port_out[e.port*WORD_WIDTH +: WORD_WIDTH];
        3: act = WORD_WIDTH'(read_hit);
        default: act = WORD_WIDTH'(read_miss);
      endcase
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s: got %h want %h", e.name, act, e.exp);
      end
    end
  end
  initial begin
    expect_state(0, 0, 0, "rst_full");
    expect_state(1, 0, 0, "rst_ready");
    expect_state(3, 0, 0, "rst_hit");
    expect_state(4, 0, 0, "rst_miss");
    @(negedge clock);
    #1;
    reset = 0;
    step();
    expect_state(1, 0, 8'hFF, "post_rst_ready");
    for (int i = 0; i < PORT_COUNT; i++) expect_state(2, i, 0, "post_rst_out");
    step();
    port_in[2*WORD_WIDTH +: WORD_WIDTH] = 36'h123456789;
    port_in_valid = 8'b0000_0100;
    step();
    port_in_valid = '0;
    expect_state(0, 0, 8'b0000_0100, "t1_full");
    expect_state(2, 2, 36'h123456789, "t1_out2");
    expect_state(1, 0, 8'b1111_1011, "t1_ready");
    issue_read(125, 1, 0, "t2_hit");
    step();
    read_en = 0;
    expect_state(0, 0, 8'h00, "t2_full");
    expect_state(2, 2, 36'h123456789, "t2_out2_kept");
    issue_read(126, 0, 1, "t3_miss");
    step();
    read_en = 0;
    expect_state(0, 0, 8'h00, "t3_full");
    for (int i = 0; i < PORT_COUNT; i++) port_in[i*WORD_WIDTH +: WORD_WIDTH] = 36'h100000000 + WORD_WIDTH'(i);
    port_in_valid = 8'hFF;
    step();
    port_in_valid = '0;
    expect_state(0, 0, 8'hFF, "t4_fill");
    expect_state(1, 0, 8'h00, "t4_ready");
    issue_read(122, 0, 0, "t4_below");
    step();
    issue_read(131, 0, 0, "t4_above");
    step();
    read_en = 0;
    expect_state(0, 0, 8'hFF, "t4_full_kept");
    for (int i = 1; i < PORT_COUNT; i++) begin
      issue_read(123 + i, 1, 0, "t5_drain");
      step();
    end
    read_en = 0;
    expect_state(0, 0, 8'h01, "t5_drained");
    for (int i = 0; i < PORT_COUNT; i++) port_in[i*WORD_WIDTH +: WORD_WIDTH] = 36'hA00000000 + WORD_WIDTH'(i * 17);
    port_in_valid = 8'hFF;
    issue_read(123, 1, 0, "t5_pop0");
    step();
    read_en = 0;
    port_in_valid = 8'h01;
    expect_state(0, 0, 8'hFE, "t5_full");
    expect_state(1, 0, 8'h01, "t5_ready");
    expect_state(2, 0, 36'h100000000, "t5_out0_old");
    expect_state(2, 1, 36'hA00000011, "t5_out1");
    expect_state(2, 7, 36'hA00000077, "t5_out7");
    step();
    port_in_valid = '0;
    expect_state(0, 0, 8'hFF, "t5_refill");
    expect_state(2, 0, 36'hA00000000, "t5_out0_new");
    step();
    #2;
    reset = 1;
    expect_state(0, 0, 0, "t6_full");
    expect_state(1, 0, 0, "t6_ready");
    expect_state(3, 0, 0, "t6_hit");
    expect_state(4, 0, 0, "t6_miss");
    @(negedge clock);
    #1;
    reset = 0;
    step();
    expect_state(1, 0, 8'hFF, "t6_ready_after");
    for (int i = 0; i < PORT_COUNT; i++) expect_state(2, i, 0, "t6_out_zero");
    repeat (2) @(negedge clock);
    #1;
    total++;
    if (sq.size() != 0 || rq.size() != 0) begin
      bad++;
      $display("FAIL queues_drained: got sq=%0d rq=%0d want 0 0", sq.size(), rq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
